// File: rtl/trace_pkg.sv
// Commit-record type, failure codes and checker states.
// Define TRACE_CHECK_REGWRITE_EN to carry and compare we/rd/wdata.
package trace_pkg;

    typedef struct packed {
`ifdef TRACE_CHECK_REGWRITE_EN
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
    } rec_t;

    localparam int unsigned REC_W = $bits(rec_t);

    localparam logic [2:0] FF_NONE  = 3'd0;
    localparam logic [2:0] FF_PC    = 3'd1;
    localparam logic [2:0] FF_INSTR = 3'd2;
    localparam logic [2:0] FF_WE    = 3'd3;
    localparam logic [2:0] FF_RD    = 3'd4;
    localparam logic [2:0] FF_WDATA = 3'd5;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_FAIL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // First differing field wins; register fields only matter on a write.
    function automatic logic [2:0] first_diff(rec_t c, rec_t e);
        logic [2:0] code;
        code = FF_NONE;
        if (c.pc != e.pc)
            code = FF_PC;
        else if (c.instr != e.instr)
            code = FF_INSTR;
`ifdef TRACE_CHECK_REGWRITE_EN
        else if (c.we != e.we)
            code = FF_WE;
        else if (c.we && (c.rd != e.rd))
            code = FF_RD;
        else if (c.we && (c.rd != 5'd0) && (c.wdata != e.wdata))
            code = FF_WDATA;
`endif
        return code;
    endfunction

endpackage

// File: rtl/trace_checker_if.sv
// Commit stream and golden-trace stream of the trace checker.
// The CPU/trace side is master; the checker is slave.
interface trace_checker_if;

    logic        commit_valid;
    logic        commit_stall;
    logic [31:0] commit_pc;
    logic [31:0] commit_instr;
    logic        commit_we;
    logic [4:0]  commit_rd;
    logic [31:0] commit_wdata;

    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wdata;

    modport master (
        output commit_valid, commit_pc, commit_instr,
        output commit_we, commit_rd, commit_wdata,
        output exp_valid, exp_pc, exp_instr,
        output exp_we, exp_rd, exp_wdata,
        input  commit_stall, exp_ready
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr,
        input  commit_we, commit_rd, commit_wdata,
        input  exp_valid, exp_pc, exp_instr,
        input  exp_we, exp_rd, exp_wdata,
        output commit_stall, exp_ready
    );

endinterface

// File: rtl/trace_fifo.sv
// Commit-record buffer; a pop frees the slot a same-cycle push
// lands in, so a full FIFO can push and pop together.
module trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push)
                wr_q <= wr_q + 1'b1;
            if (do_pop)
                rd_q <= rd_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push)
            mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/trace_checker.sv
// Compares retired instructions against a golden trace stream.
// TRACE_CHECK_REGWRITE_EN also checks register-file writes.
module trace_checker
    import trace_pkg::*;
#(
    parameter logic [31:0] PC_BASE    = 32'h00400000,
    parameter int unsigned MAX_CHECKS = 1500,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk_in,
    input  logic           reset,
    trace_checker_if.slave tif,
    output logic [31:0]    checked_count,
    output logic           mismatch,
    output logic [2:0]     fail_field,
    output logic [31:0]    fail_index,
    output logic           done,
    output logic           pass
);

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] index_q, index_d;
    logic [2:0]  field_q, field_d;
    logic        mism_q, mism_d;

    rec_t        push_rec;
    rec_t        head_rec;
    rec_t        exp_rec;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;
    logic [2:0]  code;

    assign tif.exp_ready    = (state_q == ST_RUN) && !empty;
    assign pop              = tif.exp_ready && tif.exp_valid;
    assign tif.commit_stall = full && !pop;
    assign push             = tif.commit_valid && !tif.commit_stall;

    // PC is rebased on entry so the buffer holds trace-relative records.
    always_comb begin
        push_rec       = '0;
        push_rec.pc    = tif.commit_pc - PC_BASE;
        push_rec.instr = tif.commit_instr;
        exp_rec        = '0;
        exp_rec.pc     = tif.exp_pc;
        exp_rec.instr  = tif.exp_instr;
`ifdef TRACE_CHECK_REGWRITE_EN
        push_rec.we    = tif.commit_we;
        push_rec.rd    = tif.commit_rd;
        push_rec.wdata = tif.commit_wdata;
        exp_rec.we     = tif.exp_we;
        exp_rec.rd     = tif.exp_rd;
        exp_rec.wdata  = tif.exp_wdata;
`endif
    end

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk_in  (clk_in),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_rec),
        .rdata_o (head_rec),
        .full_o  (full),
        .empty_o (empty)
    );

    assign code = first_diff(head_rec, exp_rec);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        index_d = index_q;
        field_d = field_q;
        mism_d  = mism_q;
        unique case (state_q)
            ST_RUN: begin
                if (pop) begin
                    if (code == FF_NONE) begin
                        count_d = count_q + 32'd1;
                        if (count_d == MAX_CHECKS)
                            state_d = ST_DONE;
                    end else begin
                        mism_d  = 1'b1;
                        field_d = code;
                        index_d = count_q;
                        state_d = ST_FAIL;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            count_q <= '0;
            index_q <= '0;
            field_q <= '0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            index_q <= index_d;
            field_q <= field_d;
            mism_q  <= mism_d;
        end
    end

    assign checked_count = count_q;
    assign mismatch      = mism_q;
    assign fail_field    = field_q;
    assign fail_index    = index_q;
    assign done          = (state_q != ST_RUN);
    assign pass          = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_checker.sv
// Randomised commit/golden streams against a queue-based reference model.
// Define TRACE_CHECK_REGWRITE_EN to exercise register-write checks.
module tb_trace_checker;

    localparam logic [31:0] BASE  = 32'h00400000;
    localparam int          MAXC  = 1500;
    localparam int          DEPTH = 4;
`ifdef TRACE_CHECK_REGWRITE_EN
    localparam int          NF    = 5;
`else
    localparam int          NF    = 2;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic        we;
        logic [4:0]  rd;
    } trec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] checked_count;
    logic [31:0] fail_index;
    logic [2:0]  fail_field;
    logic        mismatch;
    logic        done;
    logic        pass;

    always #5 clk = ~clk;

    trace_checker_if tif();

    trace_checker #(
        .PC_BASE    (BASE),
        .MAX_CHECKS (MAXC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_in        (clk),
        .reset         (rst_n),
        .tif           (tif),
        .checked_count (checked_count),
        .mismatch      (mismatch),
        .fail_field    (fail_field),
        .fail_index    (fail_index),
        .done          (done),
        .pass          (pass)
    );

    int    n_vec = 0;
    int    n_err = 0;

    // Reference model: pending commits, run mode (0 run, 1 fail, 2 done).
    trec_t cq[$];
    int    m_st;
    int    m_cnt;
    int    m_fi;
    int    m_ff;
    int    m_mm;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 20)
                $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_diff(trec_t c, trec_t e);
        bit [5:1] d;
        d    = '0;
        d[1] = ((c.pc - BASE) != e.pc);
        d[2] = (c.instr != e.instr);
`ifdef TRACE_CHECK_REGWRITE_EN
        d[3] = (c.we != e.we);
        d[4] = (c.we || e.we) && (c.rd != e.rd);
        d[5] = (c.we || e.we) && (c.rd != 0) && (e.rd != 0) && (c.wdata != e.wdata);
`endif
        for (int i = 1; i <= 5; i++)
            if (d[i]) return i;
        return 0;
    endfunction

    function automatic trec_t mk(int k);
        trec_t r;
        r.pc    = BASE + 32'(4 * k);
        r.instr = $urandom();
        r.we    = 1'($urandom_range(1));
        r.rd    = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
        r.wdata = $urandom();
        return r;
    endfunction

    function automatic trec_t to_exp(trec_t r);
        trec_t e;
        e    = r;
        e.pc = r.pc - BASE;
`ifndef TRACE_CHECK_REGWRITE_EN
        e.we    = 1'($urandom_range(1));
        e.rd    = 5'($urandom_range(31));
        e.wdata = $urandom();
`endif
        return e;
    endfunction

    task automatic build(input int n, output trec_t recs[$], output trec_t exps[$]);
        recs.delete();
        exps.delete();
        for (int k = 0; k < n + 8; k++) begin
            recs.push_back(mk(k));
            if (k < n) exps.push_back(to_exp(recs[k]));
        end
    endtask

    task automatic drive(input bit cv, input trec_t c, input bit ev, input trec_t e);
        tif.commit_valid = cv;
        tif.commit_pc    = c.pc;
        tif.commit_instr = c.instr;
        tif.commit_we    = c.we;
        tif.commit_rd    = c.rd;
        tif.commit_wdata = c.wdata;
        tif.exp_valid    = ev;
        tif.exp_pc       = e.pc;
        tif.exp_instr    = e.instr;
        tif.exp_we       = e.we;
        tif.exp_rd       = e.rd;
        tif.exp_wdata    = e.wdata;
    endtask

    task automatic check_status();
        chk("checked_count", checked_count, 32'(m_cnt));
        chk("mismatch", 32'(mismatch), 32'(m_mm));
        chk("fail_field", 32'(fail_field), 32'(m_ff));
        chk("fail_index", fail_index, 32'(m_fi));
        chk("done", 32'(done), 32'(m_st != 0));
        chk("pass", 32'(pass), 32'(m_st == 2));
    endtask

    task automatic tick(input trec_t c, input trec_t e, output bit pushed, output bit popped);
        bit    rdy;
        bit    stall;
        int    code;
        trec_t h;
        rdy    = (m_st == 0) && (cq.size() != 0);
        popped = rdy && tif.exp_valid;
        stall  = (cq.size() == DEPTH) && !popped;
        pushed = tif.commit_valid && !stall;
        @(negedge clk);
        chk("exp_ready", 32'(tif.exp_ready), 32'(rdy));
        chk("commit_stall", 32'(tif.commit_stall), 32'(stall));
        if (popped) begin
            h    = cq.pop_front();
            code = first_diff(h, e);
            if (code == 0) begin
                m_cnt++;
                if (m_cnt == MAXC) m_st = 2;
            end else begin
                m_mm = 1;
                m_ff = code;
                m_fi = m_cnt;
                m_st = 1;
            end
        end
        if (pushed) cq.push_back(c);
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic do_reset();
        trec_t z;
        z = '{default: 0};
        drive(1'b0, z, 1'b0, z);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_count", checked_count, 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        chk("rst_field", 32'(fail_field), 32'd0);
        chk("rst_index", fail_index, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_stall", 32'(tif.commit_stall), 32'd0);
        chk("rst_ready", 32'(tif.exp_ready), 32'd0);
        cq.delete();
        m_st  = 0;
        m_cnt = 0;
        m_fi  = 0;
        m_ff  = 0;
        m_mm  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input trec_t recs[$], input trec_t exps[$],
                              input int ev_delay, input int pc_pct,
                              input int pe_pct, input int tail);
        int    ci;
        int    ei;
        int    cyc;
        int    limit;
        int    t;
        bit    cv;
        bit    ev;
        bit    hold;
        bit    pu;
        bit    po;
        trec_t c;
        trec_t e;
        ci    = 0;
        ei    = 0;
        cyc   = 0;
        t     = 0;
        hold  = 0;
        limit = exps.size() * 20 + 200;
        while (cyc < limit && (t < tail || (m_st == 0 && ei < exps.size()))) begin
            if (m_st != 0 || ei >= exps.size()) t++;
            cv = hold || (ci < recs.size() && $urandom_range(99) < pc_pct);
            ev = (cyc >= ev_delay) && ($urandom_range(99) < pe_pct);
            c  = recs[(ci < recs.size()) ? ci : recs.size() - 1];
            e  = (ei < exps.size()) ? exps[ei] : to_exp(mk(ei));
            drive(cv, c, ev, e);
            tick(c, e, pu, po);
            if (pu) ci++;
            if (po) ei++;
            hold = cv && !pu;
            cyc++;
        end
        chk("finished", 32'(cyc < limit), 32'd1);
        c = '{default: 0};
        drive(1'b0, c, 1'b0, c);
    endtask

    initial begin
        trec_t recs[$];
        trec_t exps[$];
        int    n;
        int    bad;
        int    fld;

        do_reset();

        // Long matching run to completion.
        build(MAXC, recs, exps);
        run_stream(recs, exps, 0, 90, 90, 10);
        chk("match_done", 32'(done), 32'd1);
        chk("match_pass", 32'(pass), 32'd1);
        chk("match_count", checked_count, 32'(MAXC));

        // Golden stream stalled while the CPU keeps retiring.
        do_reset();
        build(20, recs, exps);
        run_stream(recs, exps, 10, 100, 100, 0);
        chk("backpressure_count", checked_count, 32'd20);
        chk("backpressure_done", 32'(done), 32'd0);

        // Instruction mismatch at record 7.
        do_reset();
        build(20, recs, exps);
        recs[7].instr = 32'h20080002;
        exps[7].instr = 32'h20080001;
        run_stream(recs, exps, 0, 80, 80, 8);
        chk("instr_mismatch", 32'(mismatch), 32'd1);
        chk("instr_field", 32'(fail_field), 32'd2);
        chk("instr_index", fail_index, 32'd7);
        chk("instr_done", 32'(done), 32'd1);
        chk("instr_pass", 32'(pass), 32'd0);
        chk("instr_ready", 32'(tif.exp_ready), 32'd0);

`ifdef TRACE_CHECK_REGWRITE_EN
        // rd=0 ignores wdata; rd=8 does not.
        do_reset();
        build(12, recs, exps);
        recs[3].we = 1'b1; recs[3].rd = 5'd0; recs[3].wdata = 32'd5;
        exps[3].we = 1'b1; exps[3].rd = 5'd0; exps[3].wdata = 32'd0;
        recs[6].we = 1'b1; recs[6].rd = 5'd8; recs[6].wdata = 32'h1234;
        exps[6].we = 1'b1; exps[6].rd = 5'd8; exps[6].wdata = 32'h1235;
        run_stream(recs, exps, 0, 90, 90, 4);
        chk("wdata_field", 32'(fail_field), 32'd5);
        chk("wdata_index", fail_index, 32'd6);
`endif

        // Random single-field corruptions.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            n   = $urandom_range(5, 30);
            bad = $urandom_range(0, n - 1);
            fld = $urandom_range(1, NF);
            build(n, recs, exps);
            case (fld)
                1:       exps[bad].pc    = exps[bad].pc ^ 32'd4;
                2:       exps[bad].instr = exps[bad].instr ^ (32'd1 << $urandom_range(31));
                3:       exps[bad].we    = ~exps[bad].we;
                4:       exps[bad].rd    = exps[bad].rd ^ 5'd1;
                default: exps[bad].wdata = exps[bad].wdata ^ 32'd1;
            endcase
            run_stream(recs, exps, $urandom_range(0, 6), $urandom_range(30, 100),
                       $urandom_range(30, 100), 6);
        end

        // Reset while failed with records buffered, then a clean run.
        do_reset();
        build(20, recs, exps);
        exps[0].instr = ~exps[0].instr;
        run_stream(recs, exps, 3, 100, 100, 0);
        chk("pre_reset_mismatch", 32'(mismatch), 32'd1);
        do_reset();
        build(30, recs, exps);
        run_stream(recs, exps, 0, 70, 70, 0);
        chk("post_reset_count", checked_count, 32'd30);
        chk("post_reset_mismatch", 32'(mismatch), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
